// File: rtl/down_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes; optional tick prescaler under DOWN_TIMER_PRESCALE_EN.
// Latency: a control strobe takes effect on the next rising clk edge, and out, tc and busy are registered.
// Backpressure: none. Strobes are accepted every cycle with priority load > stop > start > count.
module down_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload, reload_nxt, out_nxt;
  logic             tc_nxt;
  logic             tick;

`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] pcnt;

  assign tick = (pcnt == PW'(PRESCALE - 1));

  // Held at zero outside RUN and cleared when leaving RUN, so every entry starts a full prescale period.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pcnt <= '0;
    end else if (state != RUN || state_nxt != RUN || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_nxt  = state;
    out_nxt    = out;
    reload_nxt = reload;
    tc_nxt     = 1'b0;
    if (load) begin
      out_nxt    = load_val;
      reload_nxt = load_val;
      state_nxt  = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !stop && out != '0) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_nxt = IDLE;
          end else if (tick) begin
            if (out > WIDTH'(1)) begin
              out_nxt = out - WIDTH'(1);
            end else if (out == WIDTH'(1)) begin
              tc_nxt = 1'b1;
              if (periodic) begin
                out_nxt = reload;
              end else begin
                out_nxt   = '0;
                state_nxt = DONE;
              end
            end
          end
        end
        DONE: begin
          if (start && !stop) begin
            out_nxt   = reload;
            state_nxt = (reload != '0) ? RUN : IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      out    <= '0;
      reload <= '0;
      tc     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      out    <= out_nxt;
      reload <= reload_nxt;
      tc     <= tc_nxt;
      busy   <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: table-driven cycle vectors through an expected-value queue, plus multi-cycle sequences.
module tb_down_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         load, start, stop, periodic;
  logic [W-1:0] load_val;
  logic [W-1:0] out;
  logic         tc, busy;

  int checks = 0;
  int errors = 0;
  int tc_count;

  typedef struct {
    logic [W-1:0] o;
    logic         t;
    logic         b;
  } exp_t;

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         st;
    logic         sp;
    logic         per;
    logic [W-1:0] eo;
    logic         et;
    logic         eb;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[$];

  down_timer #(.WIDTH(W), .PRESCALE(4)) dut (
    .clk(clk), .rstn(rstn), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .periodic(periodic), .out(out), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, queue the expectation, compare #1 after the rising edge.
  task automatic step(input logic ld, input logic [W-1:0] lv, input logic st, input logic sp,
                      input logic per, input logic [W-1:0] eo, input logic et, input logic eb,
                      input string tag);
    exp_t e;
    load = ld; load_val = lv; start = st; stop = sp; periodic = per;
    e.o = eo; e.t = et; e.b = eb;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, " scoreboard empty"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      chk({tag, " out"},  int'(out),  int'(e.o));
      chk({tag, " tc"},   int'(tc),   int'(e.t));
      chk({tag, " busy"}, int'(busy), int'(e.b));
    end
    if (tc) tc_count++;
    @(negedge clk);
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; periodic = 1'b0; load_val = '0;
    #1;
    chk("reset out", int'(out), 0);
    chk("reset tc", int'(tc), 0);
    chk("reset busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

`ifdef DOWN_TIMER_PRESCALE_EN
    tc_count = 0;
    step(1, 2, 0, 0, 0, 2, 0, 0, "ps load");
    step(0, 2, 1, 0, 0, 2, 0, 1, "ps start");
    for (int k = 1; k <= 10; k++) begin
      step(0, 2, 0, 0, 0, (k < 4) ? 4'd2 : (k < 8) ? 4'd1 : 4'd0,
           (k == 8), (k < 8), $sformatf("ps c%0d", k));
    end
    chk("ps tc pulses", tc_count, 1);
`else
    // One-shot, restart from DONE, priority, zero load.
    tbl.push_back('{1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].sp, tbl[i].per,
           tbl[i].eo, tbl[i].et, tbl[i].eb, $sformatf("tbl[%0d]", i));
    end

    // Periodic reload of 3, then drop periodic before the fifth terminal count.
    step(1, 3, 0, 0, 1, 3, 0, 0, "per load");
    step(0, 3, 1, 0, 1, 3, 0, 1, "per start");
    tc_count = 0;
    for (int k = 1; k <= 12; k++) begin
      step(0, 3, 0, 0, 1, (k % 3 == 0) ? 4'd3 : 4'(3 - (k % 3)), (k % 3 == 0), 1,
           $sformatf("per c%0d", k));
    end
    chk("per tc pulses", tc_count, 4);
    step(0, 3, 0, 0, 1, 2, 0, 1, "per c13");
    step(0, 3, 0, 0, 1, 1, 0, 1, "per c14");
    step(0, 3, 0, 0, 0, 0, 1, 0, "per oneshot");

    // Reload of 1: tc every cycle.
    step(1, 1, 0, 0, 1, 1, 0, 0, "r1 load");
    step(0, 1, 1, 0, 1, 1, 0, 1, "r1 start");
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 1, 1, 1, 1, $sformatf("r1 c%0d", k));
    step(0, 1, 0, 1, 1, 1, 0, 0, "r1 stop");

    // Pause and resume.
    step(1, 9, 0, 0, 0, 9, 0, 0, "pr load");
    step(0, 9, 1, 0, 0, 9, 0, 1, "pr start");
    for (int k = 1; k <= 3; k++) step(0, 9, 0, 0, 0, 4'(9 - k), 0, 1, $sformatf("pr dec%0d", k));
    step(0, 9, 0, 1, 0, 6, 0, 0, "pr stop");
    for (int k = 0; k < 5; k++) step(0, 9, 0, 0, 0, 6, 0, 0, $sformatf("pr hold%0d", k));
    step(0, 9, 1, 0, 0, 6, 0, 1, "pr resume");
    tc_count = 0;
    for (int k = 1; k <= 6; k++) step(0, 9, 0, 0, 0, 4'(6 - k), (k == 6), (k != 6), $sformatf("pr run%0d", k));
    chk("pr tc pulses", tc_count, 1);

    // Full-scale load, no wrap below zero.
    step(1, 15, 0, 0, 0, 15, 0, 0, "max load");
    step(0, 15, 1, 0, 0, 15, 0, 1, "max start");
    for (int k = 1; k <= 15; k++) step(0, 15, 0, 0, 0, 4'(15 - k), (k == 15), (k != 15), $sformatf("max c%0d", k));
    for (int k = 0; k < 3; k++) step(0, 15, 0, 0, 0, 0, 0, 0, $sformatf("max after%0d", k));

    // Asynchronous reset mid-run at out=8.
    step(1, 12, 0, 0, 0, 12, 0, 0, "ar load");
    step(0, 12, 1, 0, 0, 12, 0, 1, "ar start");
    for (int k = 1; k <= 4; k++) step(0, 12, 0, 0, 0, 4'(12 - k), 0, 1, $sformatf("ar c%0d", k));
    #2;
    rstn = 1'b0;
    #1;
    chk("ar out", int'(out), 0);
    chk("ar busy", int'(busy), 0);
    chk("ar tc", int'(tc), 0);
    @(negedge clk);
    rstn = 1'b1;
    step(0, 12, 0, 0, 0, 0, 0, 0, "ar idle");
    step(0, 12, 1, 0, 0, 0, 0, 0, "ar start0");
`endif

    chk("scoreboard drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
